// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of a single-port RAM.
// One transaction in flight at a time; read data returns to its owner as a one-cycle pulse.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enb,
    output logic              ram_read_enb,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StCapt  = 2'd3;

    localparam logic [2:0] LatInit = 3'(RD_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_enb_q, wr_enb_d;
    logic              rd_enb_q, rd_enb_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;

    logic grant0, grant1;
    logic win_we;

    // On contention the requester that did not win last time goes first.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

    assign req0_ready = (state_q == StIdle) & grant0;
    assign req1_ready = (state_q == StIdle) & grant1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_enb_d     = 1'b0;
        rd_enb_d     = 1'b0;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        win_we       = req1_ready ? req1_we : req0_we;

        case (state_q)
            StIdle: begin
                if (req0_ready || req1_ready) begin
                    owner_d      = req1_ready;
                    last_grant_d = req1_ready;
                    addr_d       = req1_ready ? req1_addr : req0_addr;
                    // ram_data_in only moves on writes so it holds across reads.
                    if (win_we) begin
                        wdata_d = req1_ready ? req1_wdata : req0_wdata;
                    end
                    wr_enb_d     = win_we;
                    rd_enb_d     = ~win_we;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (rd_enb_q) begin
                    cnt_d   = LatInit;
                    state_d = (RD_LAT > 1) ? StWait : StCapt;
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StCapt;
                end
            end
            StCapt: begin
                if (owner_q) begin
                    rsp1_rdata_d = ram_data_out;
                    rsp1_valid_d = 1'b1;
                end else begin
                    rsp0_rdata_d = ram_data_out;
                    rsp0_valid_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_enb_q     <= 1'b0;
            rd_enb_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_enb_q     <= wr_enb_d;
            rd_enb_q     <= rd_enb_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign ram_address   = addr_q;
    assign ram_data_in   = wdata_q;
    assign ram_write_enb = wr_enb_q;
    assign ram_read_enb  = rd_enb_q;
    assign rsp0_valid    = rsp0_valid_q;
    assign rsp1_valid    = rsp1_valid_q;
    assign rsp0_rdata    = rsp0_rdata_q;
    assign rsp1_rdata    = rsp1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: scoreboarded RD_LAT=1 instance plus a directed RD_LAT=3 instance.
module tb_ram_arbiter;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // RD_LAT=1 instance
    logic       rst1_n;
    logic       req0_valid, req0_we, req0_ready, rsp0_valid;
    logic [4:0] req0_addr;
    logic [7:0] req0_wdata, rsp0_rdata;
    logic       req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [4:0] req1_addr;
    logic [7:0] req1_wdata, rsp1_rdata;
    logic [4:0] ram_address;
    logic [7:0] ram_data_in, ram_data_out;
    logic       ram_write_enb, ram_read_enb;

    ram_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) dut (
        .clk(clk), .reset(rst1_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_enb(ram_write_enb), .ram_read_enb(ram_read_enb),
        .ram_data_out(ram_data_out)
    );

    logic [7:0] mem1 [32];
    logic [7:0] pipe1;
    always @(posedge clk) begin
        if (ram_write_enb) mem1[ram_address] <= ram_data_in;
        if (ram_read_enb) pipe1 <= mem1[ram_address];
    end
    assign ram_data_out = pipe1;

    // RD_LAT=3 instance
    logic       rst3_n;
    logic       b_req0_valid, b_req0_we, b_req0_ready, b_rsp0_valid;
    logic [4:0] b_req0_addr;
    logic [7:0] b_req0_wdata, b_rsp0_rdata;
    logic       b_req1_valid, b_req1_we, b_req1_ready, b_rsp1_valid;
    logic [4:0] b_req1_addr;
    logic [7:0] b_req1_wdata, b_rsp1_rdata;
    logic [4:0] b_ram_address;
    logic [7:0] b_ram_data_in, b_ram_data_out;
    logic       b_ram_write_enb, b_ram_read_enb;

    ram_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(rst3_n),
        .req0_valid(b_req0_valid), .req0_we(b_req0_we), .req0_addr(b_req0_addr),
        .req0_wdata(b_req0_wdata), .req0_ready(b_req0_ready), .rsp0_valid(b_rsp0_valid),
        .rsp0_rdata(b_rsp0_rdata),
        .req1_valid(b_req1_valid), .req1_we(b_req1_we), .req1_addr(b_req1_addr),
        .req1_wdata(b_req1_wdata), .req1_ready(b_req1_ready), .rsp1_valid(b_rsp1_valid),
        .rsp1_rdata(b_rsp1_rdata),
        .ram_address(b_ram_address), .ram_data_in(b_ram_data_in),
        .ram_write_enb(b_ram_write_enb), .ram_read_enb(b_ram_read_enb),
        .ram_data_out(b_ram_data_out)
    );

    logic [7:0] b_mem [32];
    logic [7:0] b_pipe [3];
    always @(posedge clk) begin
        if (b_ram_write_enb) b_mem[b_ram_address] <= b_ram_data_in;
        b_pipe[0] <= b_ram_read_enb ? b_mem[b_ram_address] : 8'h00;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_ram_data_out = b_pipe[2];

    function automatic void check(input string name, input logic [63:0] got,
                                  input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endfunction

    function automatic void flag(input string name, input logic [63:0] got);
        tests++;
        fails++;
        $display("FAIL %s: got 0x%0h, required nothing", name, got);
    endfunction

    // Scoreboard queues: grant owner, RAM op {wr, rd, addr, wdata}, response {port, data}
    logic        exp_grant_q[$];
    logic [14:0] exp_op_q[$];
    logic [8:0]  exp_rsp_q[$];

    function automatic void exp_write(input logic p, input logic [4:0] a, input logic [7:0] d);
        exp_grant_q.push_back(p);
        exp_op_q.push_back({1'b1, 1'b0, a, d});
    endfunction

    function automatic void exp_read(input logic p, input logic [4:0] a, input logic [7:0] d);
        exp_grant_q.push_back(p);
        exp_op_q.push_back({1'b0, 1'b1, a, 8'h00});
        exp_rsp_q.push_back({p, d});
    endfunction

    function automatic void mon_grant(input logic who);
        if (exp_grant_q.size() == 0) flag("unexpected_grant", 64'(who));
        else check("grant_owner", 64'(who), 64'(exp_grant_q.pop_front()));
    endfunction

    function automatic void mon_op(input logic [14:0] got);
        if (exp_op_q.size() == 0) flag("unexpected_ram_op", 64'(got));
        else check("ram_op", 64'(got), 64'(exp_op_q.pop_front()));
    endfunction

    function automatic void mon_rsp(input logic [8:0] got);
        if (exp_rsp_q.size() == 0) flag("unexpected_rsp", 64'(got));
        else check("rsp", 64'(got), 64'(exp_rsp_q.pop_front()));
    endfunction

    always @(negedge clk) begin
        if (req0_valid && req0_ready) mon_grant(1'b0);
        if (req1_valid && req1_ready) mon_grant(1'b1);
        if (ram_write_enb || ram_read_enb)
            mon_op({ram_write_enb, ram_read_enb, ram_address,
                    ram_write_enb ? ram_data_in : 8'h00});
        if (rsp0_valid) mon_rsp({1'b0, rsp0_rdata});
        if (rsp1_valid) mon_rsp({1'b1, rsp1_rdata});
    end

    // Hold each requester valid until it has completed n handshakes.
    task automatic run(input int n0, input int n1);
        int c0 = 0;
        int c1 = 0;
        int cyc = 0;
        req0_valid = (n0 > 0);
        req1_valid = (n1 > 0);
        while ((c0 < n0 || c1 < n1) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (req0_valid && req0_ready) c0++;
            if (req1_valid && req1_ready) c1++;
            @(posedge clk);
            #1;
            if (c0 >= n0) req0_valid = 1'b0;
            if (c1 >= n1) req1_valid = 1'b0;
        end
        if (c0 < n0 || c1 < n1) begin
            tests++;
            fails++;
            $display("FAIL run_timeout: got %0d/%0d grants, required %0d/%0d", c0, c1, n0, n1);
        end
    endtask

    task automatic b_wait_ready(input int p);
        logic ok = 1'b0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            ok = (p == 0) ? b_req0_ready : b_req1_ready;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL b_ready_timeout: got no ready on port %0d, required ready", p);
        end
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic found;
        rst1_n = 1'b0; rst3_n = 1'b0;
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        b_req0_valid = 0; b_req0_we = 0; b_req0_addr = '0; b_req0_wdata = '0;
        b_req1_valid = 0; b_req1_we = 0; b_req1_addr = '0; b_req1_wdata = '0;
        pipe1 = 8'h00;

        drain(2);
        check("reset_outputs", 64'({ram_address, ram_data_in, ram_write_enb, ram_read_enb,
              rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata, req0_ready, req1_ready}), 64'd0);
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        drain(1);

        // Write 0x01 to 25 then read it back on requester 0
        exp_write(1'b0, 5'd25, 8'h01);
        req0_we = 1'b1; req0_addr = 5'd25; req0_wdata = 8'h01;
        run(1, 0);
        exp_read(1'b0, 5'd25, 8'h01);
        req0_we = 1'b0;
        run(1, 0);
        drain(5);

        // req1 pulsed for one cycle while the arbiter sits in ISSUE
        exp_write(1'b0, 5'd9, 8'h99);
        req0_we = 1'b1; req0_addr = 5'd9; req0_wdata = 8'h99;
        run(1, 0);
        req1_we = 1'b0; req1_addr = 5'd9; req1_valid = 1'b1;
        @(negedge clk);
        check("issue_pulse_ready", 64'(req1_ready), 64'd0);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        drain(5);

        // Alternating grants with both requesters continuously valid
        exp_write(1'b0, 5'd3, 8'h33);
        req0_we = 1'b1; req0_addr = 5'd3; req0_wdata = 8'h33;
        run(1, 0);
        exp_write(1'b1, 5'd4, 8'h44);
        req1_we = 1'b1; req1_addr = 5'd4; req1_wdata = 8'h44;
        run(0, 1);
        exp_read(1'b0, 5'd3, 8'h33);
        exp_read(1'b1, 5'd4, 8'h44);
        exp_read(1'b0, 5'd3, 8'h33);
        exp_read(1'b1, 5'd4, 8'h44);
        req0_we = 1'b0; req1_we = 1'b0;
        run(2, 2);
        drain(6);

        // Fresh reset, then simultaneous write/read to 31: write first, read sees new data
        rst1_n = 1'b0;
        drain(2);
        check("reset2_outputs", 64'({ram_address, ram_data_in, ram_write_enb, ram_read_enb,
              rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata}), 64'd0);
        rst1_n = 1'b1;
        drain(1);
        exp_write(1'b0, 5'd31, 8'hA5);
        exp_read(1'b1, 5'd31, 8'hA5);
        req0_we = 1'b1; req0_addr = 5'd31; req0_wdata = 8'hA5;
        req1_we = 1'b0; req1_addr = 5'd31;
        run(1, 1);
        drain(6);
        check("rsp1_rdata_hold", 64'(rsp1_rdata), 64'hA5);

        check("grant_queue_empty", 64'(exp_grant_q.size()), 64'd0);
        check("op_queue_empty", 64'(exp_op_q.size()), 64'd0);
        check("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'd0);

        // RD_LAT=3: preload addr 7, then time a single read
        b_req0_we = 1'b1; b_req0_addr = 5'd7; b_req0_wdata = 8'h5C; b_req0_valid = 1'b1;
        b_wait_ready(0);
        @(posedge clk);
        #1;
        b_req0_valid = 1'b0;
        drain(4);
        b_req0_we = 1'b0; b_req0_valid = 1'b1;
        b_wait_ready(0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) b_req0_valid = 1'b0;
            @(negedge clk);
            check($sformatf("lat3_cycle_T+%0d", k),
                  64'({b_ram_read_enb, b_req0_ready, b_rsp0_valid}),
                  64'({k == 1, 1'b0, k == 5}));
            if (k == 5) check("lat3_rdata", 64'(b_rsp0_rdata), 64'h5C);
        end
        check("lat3_no_rsp1", 64'(b_rsp1_valid), 64'd0);
        drain(3);

        // Reset asserted while a requester-1 read is in WAIT
        b_req1_we = 1'b0; b_req1_addr = 5'd7; b_req1_valid = 1'b1;
        b_wait_ready(1);
        @(posedge clk);
        #1;
        b_req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst3_n = 1'b0;
        #1;
        check("wait_reset_outputs", 64'({b_ram_address, b_ram_data_in, b_ram_write_enb,
              b_ram_read_enb, b_rsp0_valid, b_rsp0_rdata, b_rsp1_valid, b_rsp1_rdata,
              b_req0_ready, b_req1_ready}), 64'd0);
        drain(2);
        rst3_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | b_rsp0_valid | b_rsp1_valid;
        end
        check("no_rsp_after_reset", 64'(seen), 64'd0);

        @(posedge clk);
        #1;
        b_req0_we = 1'b0; b_req0_addr = 5'd7; b_req0_valid = 1'b1;
        b_req1_valid = 1'b1;
        @(negedge clk);
        check("post_reset_priority", 64'({b_req0_ready, b_req1_ready}), 64'b10);
        @(posedge clk);
        #1;
        b_req0_valid = 1'b0;
        b_req1_valid = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            found = b_rsp0_valid;
        end
        check("post_reset_read", 64'({found, b_rsp0_rdata}), 64'({1'b1, 8'h5C}));

        drain(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
